// File: rtl/hdb3_pkg.sv
// Shared types and constants for the hdb3 transmit scheduler.
package hdb3_pkg;

   // Scheduler state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2
   } sched_state_e;

   // Frame header sent MSB-first ahead of every frame
   localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

   // Byte substituted for a payload slot that found no data
   localparam logic [7:0] FILL_BYTE = 8'h00;

endpackage

// File: rtl/hdb3_bit_timer.sv
// Line bit timer: counts 0..BIT_DIV-1 on enabled cycles and flags the last
// count as a tick. Frozen (no tick, count held) while i_en is low.
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_en       count enable
//   o_tick_c   combinational tick, high when enabled and count == BIT_DIV-1
module hdb3_bit_timer #(
   parameter int unsigned BIT_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_tick_c
);

   localparam int unsigned TW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_DIV - 1);

   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;

   assign o_tick_c = i_en && (timer_q == TIMER_LAST);

   // Next count: wrap on tick, hold while disabled
   always_comb begin
      timer_d = timer_q;
      if (i_en) begin
         timer_d = o_tick_c ? '0 : timer_q + TW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/hdb3_tx_sched.sv
// Transmit scheduler in front of the hdb3 encoder. Accepts bytes over a
// valid/ready handshake into a one-byte holding register, frames them as
// SYNC_WORD + FRAME_BYTES payload bytes and serializes MSB-first, one bit per
// timer tick. Idle line is zeros; a starved payload slot sends FILL_BYTE and
// bumps a saturating underrun counter.
//   i_clk / i_rst_n   clock, asynchronous active-low reset
//   i_en              enable; low freezes timer and framing position
//   i_byte_data/valid payload byte offer; o_byte_ready = holding register empty
//   o_bit/o_bit_strobe serial bit and one-cycle new-bit pulse
//   o_frame_start     with the strobe of the first SYNC_WORD bit
//   o_busy            state != IDLE
//   o_underrun_cnt    saturating count of fill bytes inserted
module hdb3_tx_sched
   import hdb3_pkg::*;
#(
   parameter int unsigned BIT_DIV     = 4,
   parameter int unsigned FRAME_BYTES = 4,
   parameter logic [7:0]  SYNC_WORD   = SYNC_WORD_DEFAULT
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic [7:0] i_byte_data,
   input  logic       i_byte_valid,
   output logic       o_byte_ready,
   output logic       o_bit,
   output logic       o_bit_strobe,
   output logic       o_frame_start,
   output logic       o_busy,
   output logic [7:0] o_underrun_cnt
);

   localparam int unsigned BCW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam logic [BCW-1:0] BYTE_LAST = BCW'(FRAME_BYTES - 1);

   sched_state_e   state_q, state_d;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic [7:0]     hold_q, hold_d;
   logic           hold_full_q, hold_full_d;
   logic           ready_q, ready_d;
   logic           bit_q, bit_d;
   logic           strobe_q, strobe_d;
   logic           fstart_q, fstart_d;
   logic           busy_q, busy_d;
   logic [7:0]     urun_q, urun_d;
   logic [7:0]     load_c;
   logic           tick_c;
   logic           accept_c;

   hdb3_bit_timer #(
      .BIT_DIV (BIT_DIV)
   ) u_bit_timer (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (i_en),
      .o_tick_c (tick_c)
   );

   // ready mirrors !hold_full, so an accept can never coincide with a load
   assign accept_c = i_byte_valid && ready_q;

   // Framing FSM, shift/holding registers and output staging
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      bit_d       = bit_q;
      strobe_d    = 1'b0;
      fstart_d    = 1'b0;
      urun_d      = urun_q;
      load_c      = FILL_BYTE;

      if (tick_c) begin
         strobe_d = 1'b1;
         unique case (state_q)
            ST_IDLE: begin
               if (hold_full_q) begin
                  bit_d     = SYNC_WORD[7];
                  fstart_d  = 1'b1;
                  state_d   = ST_SYNC;
                  bit_cnt_d = 3'd1;
               end else begin
                  bit_d = 1'b0;
               end
            end
            ST_SYNC: begin
               bit_d     = SYNC_WORD[3'd7 - bit_cnt_q];
               // bit_cnt 0 here only when chained straight from a previous frame
               fstart_d  = (bit_cnt_q == 3'd0);
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d    = ST_DATA;
                  byte_cnt_d = '0;
               end
            end
            ST_DATA: begin
               if (bit_cnt_q == 3'd0) begin
                  if (hold_full_q) begin
                     load_c      = hold_q;
                     hold_full_d = 1'b0;
                  end else begin
                     load_c = FILL_BYTE;
                     if (urun_q != 8'hFF) begin
                        urun_d = urun_q + 8'd1;
                     end
                  end
                  bit_d   = load_c[7];
                  shift_d = {load_c[6:0], 1'b0};
               end else begin
                  bit_d   = shift_q[7];
                  shift_d = {shift_q[6:0], 1'b0};
               end
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (byte_cnt_q == BYTE_LAST) begin
                     byte_cnt_d = '0;
                     state_d    = hold_full_q ? ST_SYNC : ST_IDLE;
                  end else begin
                     byte_cnt_d = byte_cnt_q + BCW'(1);
                  end
               end
            end
            default: begin
               state_d   = ST_IDLE;
               bit_cnt_d = 3'd0;
            end
         endcase
      end

      if (accept_c) begin
         hold_d      = i_byte_data;
         hold_full_d = 1'b1;
      end

      ready_d = !hold_full_d;
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         byte_cnt_q  <= '0;
         shift_q     <= 8'h00;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         ready_q     <= 1'b1;
         bit_q       <= 1'b0;
         strobe_q    <= 1'b0;
         fstart_q    <= 1'b0;
         busy_q      <= 1'b0;
         urun_q      <= 8'h00;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         ready_q     <= ready_d;
         bit_q       <= bit_d;
         strobe_q    <= strobe_d;
         fstart_q    <= fstart_d;
         busy_q      <= busy_d;
         urun_q      <= urun_d;
      end
   end

   assign o_byte_ready   = ready_q;
   assign o_bit          = bit_q;
   assign o_bit_strobe   = strobe_q;
   assign o_frame_start  = fstart_q;
   assign o_busy         = busy_q;
   assign o_underrun_cnt = urun_q;

endmodule

// File: tb/tb_hdb3_tx_sched.sv
// Scoreboard bench for hdb3_tx_sched: a frame-position reference model
// predicts each strobed bit; a negedge monitor pops and compares.
module tb_hdb3_tx_sched;

   localparam int unsigned BIT_DIV     = 4;
   localparam int unsigned FRAME_BYTES = 4;
   localparam logic [7:0]  SYNC        = 8'hA5;
   localparam int          NFRAME      = 8 * (1 + FRAME_BYTES);

   typedef struct packed {
      logic       b;
      logic       fs;
      logic       busy;
      logic [7:0] urun;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       i_en;
   logic [7:0] i_byte_data;
   logic       i_byte_valid;
   logic       o_byte_ready;
   logic       o_bit;
   logic       o_bit_strobe;
   logic       o_frame_start;
   logic       o_busy;
   logic [7:0] o_underrun_cnt;

   int tests = 0;
   int fails = 0;
   int strobe_seen = 0;
   int fstart_seen = 0;

   // reference model state
   exp_t       q[$];
   int         m_pos;
   logic [7:0] m_cur;
   logic [7:0] m_hold;
   logic       m_hold_v;
   int         m_urun;
   int         en_cnt;
   logic       exp_strobe;
   logic [7:0] sync_v;

   hdb3_tx_sched #(
      .BIT_DIV     (BIT_DIV),
      .FRAME_BYTES (FRAME_BYTES),
      .SYNC_WORD   (SYNC)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_en           (i_en),
      .i_byte_data    (i_byte_data),
      .i_byte_valid   (i_byte_valid),
      .o_byte_ready   (o_byte_ready),
      .o_bit          (o_bit),
      .o_bit_strobe   (o_bit_strobe),
      .o_frame_start  (o_frame_start),
      .o_busy         (o_busy),
      .o_underrun_cnt (o_underrun_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: a frame is NFRAME line positions; slot 0 is the sync word.
   always @(posedge clk or negedge rst_n) begin
      logic acc;
      logic b, fs, bz;
      int   slot, k;
      exp_t e;
      if (!rst_n) begin
         q.delete();
         m_pos = -1; m_cur = 8'h00; m_hold = 8'h00; m_hold_v = 1'b0;
         m_urun = 0; en_cnt = 0; exp_strobe = 1'b0;
      end else begin
         acc = i_byte_valid && !m_hold_v;
         exp_strobe = 1'b0;
         if (i_en) begin
            if (en_cnt % BIT_DIV == BIT_DIV - 1) begin
               exp_strobe = 1'b1;
               fs = 1'b0;
               if (m_pos < 0 && m_hold_v) m_pos = 0;
               if (m_pos < 0) begin
                  b = 1'b0; bz = 1'b0;
               end else begin
                  fs   = (m_pos == 0);
                  slot = m_pos / 8;
                  k    = m_pos % 8;
                  if (slot == 0) begin
                     b = sync_v[7-k];
                  end else begin
                     if (k == 0) begin
                        if (m_hold_v) begin
                           m_cur = m_hold; m_hold_v = 1'b0;
                        end else begin
                           m_cur = 8'h00;
                           if (m_urun < 255) m_urun++;
                        end
                     end
                     b = m_cur[7-k];
                  end
                  m_pos++;
                  if (m_pos == NFRAME) begin
                     m_pos = -1;
                     bz = m_hold_v;
                  end else begin
                     bz = 1'b1;
                  end
               end
               e.b = b; e.fs = fs; e.busy = bz; e.urun = 8'(m_urun);
               q.push_back(e);
            end
            en_cnt++;
         end
         if (acc) begin
            m_hold = i_byte_data; m_hold_v = 1'b1;
         end
      end
   end

   // Monitor: compare every strobe against the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         chk("strobe_timing", 32'(o_bit_strobe), 32'(exp_strobe));
         chk("byte_ready", 32'(o_byte_ready), 32'(!m_hold_v));
         if (o_bit_strobe) begin
            strobe_seen++;
            if (o_frame_start) fstart_seen++;
            if (q.size() == 0) begin
               chk("unexpected_strobe", 32'(q.size()), 32'd1);
            end else begin
               e = q.pop_front();
               chk("bit", 32'(o_bit), 32'(e.b));
               chk("frame_start", 32'(o_frame_start), 32'(e.fs));
               chk("busy", 32'(o_busy), 32'(e.busy));
               chk("underrun_cnt", 32'(o_underrun_cnt), 32'(e.urun));
            end
         end
      end
   end

   task automatic check_reset_vals();
      chk("rst_ready", 32'(o_byte_ready), 32'd1);
      chk("rst_bit", 32'(o_bit), 32'd0);
      chk("rst_strobe", 32'(o_bit_strobe), 32'd0);
      chk("rst_fstart", 32'(o_frame_start), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_urun", 32'(o_underrun_cnt), 32'd0);
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge
   task automatic send_byte(input logic [7:0] d);
      int n = 0;
      i_byte_valid = 1'b1;
      i_byte_data  = d;
      while (!o_byte_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!o_byte_ready) begin
         chk("send_timeout", 32'(n), 32'd0);
      end else begin
         @(negedge clk);
      end
      i_byte_valid = 1'b0;
   endtask

   task automatic idle_bits(input int n);
      repeat (n * BIT_DIV) @(negedge clk);
   endtask

   task automatic wait_strobes(input int n);
      int target = strobe_seen + n;
      int c = 0;
      while (strobe_seen < target && c < n * BIT_DIV * 8 + 100) begin
         @(negedge clk);
         c++;
      end
      if (strobe_seen < target) chk("strobe_wait_timeout", 32'(strobe_seen), 32'(target));
   endtask

   task automatic wait_fstart();
      int target = fstart_seen + 1;
      int c = 0;
      while (fstart_seen < target && c < 1000) begin
         @(negedge clk);
         c++;
      end
      if (fstart_seen < target) chk("fstart_wait_timeout", 32'(fstart_seen), 32'(target));
   endtask

   task automatic send4(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
      send_byte(a); send_byte(b); send_byte(c); send_byte(d);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sync_v       = SYNC;
      rst_n        = 1'b0;
      i_en         = 1'b1;
      i_byte_valid = 1'b0;
      i_byte_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_vals();
      rst_n = 1'b1;

      // 1: idle line
      idle_bits(40);
      chk("idle_busy", 32'(o_busy), 32'd0);
      chk("idle_urun", 32'(o_underrun_cnt), 32'd0);

      // 2: full frame, fixed bytes
      send4(8'h12, 8'h34, 8'h56, 8'h78);
      idle_bits(60);

      // 3: single byte then starvation
      send_byte(8'hFF);
      idle_bits(60);
      chk("urun_after_single", 32'(o_underrun_cnt), 32'd3);

      // 4: nine back-to-back bytes
      for (int i = 0; i < 9; i++) send_byte(8'($urandom));
      idle_bits(100);

      // 5: enable dropped mid-DATA for 17 clocks
      fork
         send4(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         begin
            wait_fstart();
            wait_strobes(8 + 8 + 3);
            i_en = 1'b0;
            repeat (17) @(negedge clk);
            i_en = 1'b1;
         end
      join
      idle_bits(60);

      // 6: asynchronous reset mid-SYNC
      send_byte(8'h3C);
      wait_fstart();
      wait_strobes(2);
      #2 rst_n = 1'b0;
      #1 check_reset_vals();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      send4(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      idle_bits(60);

      // 7: random gaps and enable drops
      fork
         for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            send_byte(8'($urandom));
         end
         for (int j = 0; j < 6; j++) begin
            repeat ($urandom_range(20, 150)) @(negedge clk);
            i_en = 1'b0;
            repeat ($urandom_range(1, 20)) @(negedge clk);
            i_en = 1'b1;
         end
      join
      i_en = 1'b1;
      idle_bits(100);

      // 8: underrun counter saturation
      for (int i = 0; i < 90; i++) begin
         send_byte(8'($urandom));
         idle_bits(44);
      end
      chk("urun_saturated", 32'(o_underrun_cnt), 32'd255);

      idle_bits(4);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
